// File: rtl/shift_pipe.sv
// Two-stage pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready flow control and flush.
// Build option: define SHIFT_PIPE_ROTATE_EN to make op 11 a rotate-right; otherwise op 11 is SRL.
module shift_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result
);

  localparam int FINE_W   = SHAMT_W / 2;
  localparam int COARSE_W = SHAMT_W - FINE_W;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // Shared by both stages: the same shift is applied with a coarse or a fine amount.
  function automatic logic [WIDTH-1:0] shift_fn(
    input logic [1:0]         op,
    input logic [WIDTH-1:0]   data,
    input logic               sign,
    input logic [SHAMT_W-1:0] amt
  );
    logic [WIDTH-1:0] fill;
`ifdef SHIFT_PIPE_ROTATE_EN
    logic [2*WIDTH-1:0] dbl;
`endif
    fill = ~({WIDTH{1'b1}} >> amt);
    case (op)
      OP_SLL:  shift_fn = data << amt;
      OP_SRL:  shift_fn = data >> amt;
      OP_SRA:  shift_fn = (data >> amt) | (sign ? fill : '0);
      default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
        dbl      = {data, data} >> amt;
        shift_fn = dbl[WIDTH-1:0];
`else
        shift_fn = data >> amt;
`endif
      end
    endcase
  endfunction

  logic               s1_valid_q, s1_valid_d;
  logic [1:0]         s1_op_q, s1_op_d;
  logic               s1_sign_q, s1_sign_d;
  logic [FINE_W-1:0]  s1_fine_q, s1_fine_d;
  logic [WIDTH-1:0]   s1_data_q, s1_data_d;
  logic               o_valid_q, o_valid_d;
  logic [WIDTH-1:0]   o_result_q, o_result_d;

  logic               s2_advance;
  logic               s1_advance;
  logic               accept;
  logic [SHAMT_W-1:0] coarse_amt;
  logic [SHAMT_W-1:0] fine_amt;
  logic [WIDTH-1:0]   coarse_data;
  logic [WIDTH-1:0]   fine_data;
  logic               unused_operand_b;

  // Upper shift-amount bits are ignored by definition.
  assign unused_operand_b = ^i_operand_b[WIDTH-1:SHAMT_W];

  assign s2_advance = !o_valid_q || i_ready;
  assign s1_advance = s2_advance;
  assign o_ready    = !s1_valid_q || s1_advance;
  assign accept     = i_valid && o_ready && !i_flush;

  always_comb begin
    coarse_amt  = {i_operand_b[SHAMT_W-1:FINE_W], {FINE_W{1'b0}}};
    fine_amt    = {{COARSE_W{1'b0}}, s1_fine_q};
    coarse_data = shift_fn(i_op, i_operand_a, i_operand_a[WIDTH-1], coarse_amt);
    fine_data   = shift_fn(s1_op_q, s1_data_q, s1_sign_q, fine_amt);
  end

  always_comb begin
    s1_op_d   = s1_op_q;
    s1_sign_d = s1_sign_q;
    s1_fine_d = s1_fine_q;
    s1_data_d = s1_data_q;
    if (accept) begin
      s1_op_d   = i_op;
      s1_sign_d = i_operand_a[WIDTH-1];
      s1_fine_d = i_operand_b[FINE_W-1:0];
      s1_data_d = coarse_data;
    end
    // When the slot frees (or was empty) it holds only what was accepted this cycle.
    if (i_flush) begin
      s1_valid_d = 1'b0;
    end else if (o_ready) begin
      s1_valid_d = accept;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  always_comb begin
    o_result_d = o_result_q;
    if (i_flush) begin
      o_valid_d = 1'b0;
    end else if (s2_advance) begin
      o_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        o_result_d = fine_data;
      end
    end else begin
      o_valid_d = o_valid_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_sign_q  <= 1'b0;
      s1_fine_q  <= '0;
      s1_data_q  <= '0;
      o_valid_q  <= 1'b0;
      o_result_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_sign_q  <= s1_sign_d;
      s1_fine_q  <= s1_fine_d;
      s1_data_q  <= s1_data_d;
      o_valid_q  <= o_valid_d;
      o_result_q <= o_result_d;
    end
  end

  assign o_valid  = o_valid_q;
  assign o_result = o_result_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe (WIDTH=32): directed scenarios plus a random-backpressure run.
module tb_shift_pipe;

  logic        clk;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [31:0] i_operand_a;
  logic [31:0] i_operand_b;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;

  int          vectors;
  int          miscompares;
  logic [31:0] sb[$];
  logic        rnd_rdy;

  shift_pipe #(.WIDTH(32)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op       (i_op),
    .i_operand_a(i_operand_a),
    .i_operand_b(i_operand_b),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [4:0]         sh;
    logic signed [31:0] sa;
    sh = b[4:0];
    sa = a;
    case (op)
      2'b00:   return a << sh;
      2'b01:   return a >> sh;
      2'b10:   return sa >>> sh;
      default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
        return (a >> sh) | (a << (6'd32 - {1'b0, sh}));
`else
        return a >> sh;
`endif
      end
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int edges);
    logic took;
    took  = 1'b0;
    edges = 0;
    i_valid = 1'b1;
    i_op = op;
    i_operand_a = a;
    i_operand_b = b;
    for (int t = 0; t < 60 && !took; t++) begin
      if (rnd_rdy) i_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = o_ready;
      @(posedge clk);
      edges++;
      if (took) sb.push_back(model(op, a, b));
      #1;
    end
    i_valid = 1'b0;
    if (!took) check("accept_timeout", 64'(took), 64'd1);
  endtask

  task automatic wait_drain();
    i_ready = 1'b1;
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output side of the scoreboard: every handshake pops one expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (!i_reset && o_valid && i_ready) begin
        if (sb.size() == 0) check("spurious_out", 64'(sb.size()), 64'd1);
        else check("result", 64'(o_result), 64'(sb.pop_front()));
      end
    end
  end

  logic [1:0]  dir_op [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2};
  logic [31:0] dir_a  [12] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h1234_5678,
                               32'h8000_0000, 32'h8000_0001, 32'h7FFF_FFFF, 32'h0000_0001,
                               32'hA5A5_0F0F, 32'hCAFE_F00D, 32'h0F0F_0F0F, 32'hF000_0000};
  logic [31:0] dir_b  [12] = '{32'd31, 32'd0, 32'h21, 32'd31, 32'd31, 32'd0, 32'd31, 32'd1,
                               32'd13, 32'hFFFF_FFE7, 32'd6, 32'd3};

  initial begin
    int          e;
    int          total;
    logic [31:0] held;
    logic [31:0] exp_ror;

    vectors = 0;
    miscompares = 0;
    rnd_rdy = 1'b0;
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_op = 2'b00;
    i_operand_a = '0;
    i_operand_b = '0;
    i_flush = 1'b0;
    i_ready = 1'b1;

    @(negedge clk);
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_result", 64'(o_result), 64'd0);
    check("rst_o_ready", 64'(o_ready), 64'd1);
    #2 i_reset = 1'b0;
    @(posedge clk);
    #1;

    // SRA latency: S1 after the accept edge, o_valid after the next one.
    send(2'd2, 32'h8000_0000, 32'd4, e);
    check("lat_s1_only", 64'(o_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_o_valid", 64'(o_valid), 64'd1);
    check("sra_result", 64'(o_result), 64'hF800_0000);
    wait_drain();

    for (int i = 0; i < 12; i++) send(dir_op[i], dir_a[i], dir_b[i], e);
    wait_drain();

    // Full throughput with i_ready held high.
    total = 0;
    for (int i = 0; i < 16; i++) begin
      send(2'($urandom_range(0, 3)), $urandom, $urandom, e);
      total += e;
    end
    check("throughput_edges", 64'(total), 64'd16);
    wait_drain();

    // Backpressure: two accepted, third refused, output held.
    i_ready = 1'b0;
    send(2'd0, 32'd1, 32'd1, e);
    send(2'd0, 32'd1, 32'd2, e);
    i_valid = 1'b1;
    i_op = 2'd0;
    i_operand_a = 32'd1;
    i_operand_b = 32'd3;
    @(negedge clk);
    check("stall_o_ready", 64'(o_ready), 64'd0);
    check("stall_first", 64'(o_result), 64'h2);
    held = o_result;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_hold_val", 64'(o_result), 64'(held));
      check("stall_hold_vld", 64'(o_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    send(2'd0, 32'd1, 32'd3, e);
    check("no_bubble_o_valid", 64'(o_valid), 64'd1);
    wait_drain();

    // Flush with two in flight and a competing request.
    i_ready = 1'b0;
    send(2'd1, 32'hFFFF_0000, 32'd4, e);
    send(2'd0, 32'h0000_00FF, 32'd8, e);
    i_valid = 1'b1;
    i_op = 2'd0;
    i_operand_a = 32'h1;
    i_operand_b = 32'd5;
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    sb.delete();
    check("flush_o_valid", 64'(o_valid), 64'd0);
    check("flush_o_ready", 64'(o_ready), 64'd1);
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flush_empty", 64'(o_valid), 64'd0);
    end
    @(posedge clk);
    #1;

`ifdef SHIFT_PIPE_ROTATE_EN
    exp_ror = 32'h8000_0000;
`else
    exp_ror = 32'h0000_0000;
`endif
    send(2'd3, 32'h1, 32'd1, e);
    @(posedge clk);
    #1;
    check("ror_result", 64'(o_result), 64'(exp_ror));
    wait_drain();

    // Asynchronous reset with both stages occupied.
    i_ready = 1'b0;
    send(2'd0, 32'h3, 32'd2, e);
    send(2'd1, 32'h80, 32'd3, e);
    @(negedge clk);
    #2 i_reset = 1'b1;
    #1;
    check("arst_o_valid", 64'(o_valid), 64'd0);
    check("arst_o_result", 64'(o_result), 64'd0);
    check("arst_o_ready", 64'(o_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #3 i_reset = 1'b0;
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    send(2'd2, 32'hFFFF_FF00, 32'd8, e);
    check("post_rst_s1_only", 64'(o_valid), 64'd0);
    @(posedge clk);
    #1;
    check("post_rst_o_valid", 64'(o_valid), 64'd1);
    check("post_rst_result", 64'(o_result), 64'hFFFF_FFFF);
    wait_drain();

    // Random backpressure run.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(2'($urandom_range(0, 3)), $urandom, $urandom, e);
    end
    rnd_rdy = 1'b0;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
